// File: rtl/noc_out_pkg.sv
// -----------------------------------------------------------------------------
// noc_out_pkg
// Shared constants and helpers for the NoC output collector.
//   MODE_SINK / MODE_FORWARD : values of the collector's FORWARD parameter
//   ptr_width()              : FIFO address width for a power-of-two depth
//   sat_inc()                : increment that sticks at a given maximum
// -----------------------------------------------------------------------------
package noc_out_pkg;

   localparam int MODE_SINK    = 0;
   localparam int MODE_FORWARD = 1;

   // Address bits needed to index DEPTH entries (at least one bit).
   function automatic int ptr_width(input int depth);
      int w;
      if (depth > 1) begin
         w = $clog2(depth);
      end else begin
         w = 1;
      end
      return w;
   endfunction

   // Increment that holds at limit instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
      logic [31:0] result;
      if (value < limit) begin
         result = value + 32'd1;
      end else begin
         result = value;
      end
      return result;
   endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// -----------------------------------------------------------------------------
// noc_sync_fifo
// Single-clock FIFO with first-word-fall-through head. Full/empty use one
// extra pointer bit so all DEPTH entries are usable.
//   CLK, RST : clock, async active-high reset
//   clear    : synchronous flush, wins over push and pop
//   push/din : write din when not full
//   pop      : discard head when not empty
//   dout     : current head entry
//   full/empty : occupancy flags (registered pointers only)
// -----------------------------------------------------------------------------
module noc_sync_fifo
   import noc_out_pkg::*;
#(
   parameter int WIDTH = 39,
   parameter int DEPTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = ptr_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout    = mem[rd_ptr[AW-1:0]];

   // Read/write pointers; clear simply re-aligns them, discarding contents.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   // Storage array; contents are only meaningful between the pointers.
   always_ff @(posedge CLK) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/noc_output_collector.sv
// -----------------------------------------------------------------------------
// noc_output_collector
// AXI-Stream egress endpoint: buffers beats, counts beats/good packets (total
// and per TID), flags wrong-destination beats, keeps the last packet result
// and raises DONE after NUM_EXPECTED good packets. SINK mode drains the FIFO
// internally; FORWARD mode passes beats to the master port.
//   CLK, RST      : clock, async active-high reset
//   CLEAR         : synchronous flush of FIFO and all status
//   DONE, DEST_ERR: sticky status flags
//   BEAT_CNT, PKT_CNT, ID_PKT_CNT, LAST_RESULT : registered statistics
//   AXIS_S_*      : slave stream in (TREADY from registered state and CLEAR)
//   AXIS_M_*      : master stream out (all zero in SINK mode)
// -----------------------------------------------------------------------------
module noc_output_collector
   import noc_out_pkg::*;
#(
   parameter int TDATAW       = 32,
   parameter int TDESTW       = 4,
   parameter int TIDW         = 2,
   parameter int DEPTH        = 8,
   parameter int CNTW         = 16,
   parameter int RESW         = 9,
   parameter int LOCAL_DEST   = 0,
   parameter int NUM_EXPECTED = 16,
   parameter int FORWARD      = MODE_SINK
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         CLEAR,
   output logic                         DONE,
   output logic                         DEST_ERR,
   output logic [CNTW-1:0]              BEAT_CNT,
   output logic [CNTW-1:0]              PKT_CNT,
   output logic [(2**TIDW)*CNTW-1:0]    ID_PKT_CNT,
   output logic [RESW-1:0]              LAST_RESULT,
   input  logic                         AXIS_S_TVALID,
   output logic                         AXIS_S_TREADY,
   input  logic [TDATAW-1:0]            AXIS_S_TDATA,
   input  logic                         AXIS_S_TLAST,
   input  logic [TIDW-1:0]              AXIS_S_TID,
   input  logic [TDESTW-1:0]            AXIS_S_TDEST,
   output logic                         AXIS_M_TVALID,
   input  logic                         AXIS_M_TREADY,
   output logic [TDATAW-1:0]            AXIS_M_TDATA,
   output logic                         AXIS_M_TLAST,
   output logic [TIDW-1:0]              AXIS_M_TID,
   output logic [TDESTW-1:0]            AXIS_M_TDEST
);

   localparam int            EW     = TDATAW + 1 + TIDW + TDESTW;
   localparam int            NID    = 2**TIDW;
   localparam bit            IS_FWD = (FORWARD == MODE_FORWARD);
   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic              ready_en;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic [EW-1:0]     head;
   logic [TDATAW-1:0] head_data;
   logic              head_last;
   logic [TIDW-1:0]   head_tid;
   logic [TDESTW-1:0] head_dest;
   logic              dest_ok;
   logic [CNTW-1:0]   pkt_next;
   logic [CNTW-1:0]   beat_cnt;
   logic [CNTW-1:0]   pkt_cnt;
   logic [CNTW-1:0]   id_cnt [NID];
   logic [RESW-1:0]   last_result;
   logic              done;
   logic              dest_err;

   // ready_en keeps TREADY low while in reset and for the first edge after it.
   assign AXIS_S_TREADY = ready_en && !fifo_full && !CLEAR;
   assign fifo_push     = AXIS_S_TVALID && AXIS_S_TREADY;
   assign fifo_pop      = IS_FWD ? (!fifo_empty && AXIS_M_TREADY) : !fifo_empty;

   assign head_data = head[EW-1 -: TDATAW];
   assign head_last = head[TIDW + TDESTW];
   assign head_tid  = head[TDESTW +: TIDW];
   assign head_dest = head[TDESTW-1:0];
   assign dest_ok   = (head_dest == TDESTW'(LOCAL_DEST));
   assign pkt_next  = CNTW'(sat_inc(32'(pkt_cnt), 32'(CNT_MAX)));

   noc_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .clear (CLEAR),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({AXIS_S_TDATA, AXIS_S_TLAST, AXIS_S_TID, AXIS_S_TDEST}),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Input-ready enable, low only while reset is (or has just been) applied.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
      end
   end

   // Statistics and sticky flags updated on every pop; CLEAR wins.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         beat_cnt    <= '0;
         pkt_cnt     <= '0;
         last_result <= '0;
         done        <= 1'b0;
         dest_err    <= 1'b0;
         for (int k = 0; k < NID; k++) begin
            id_cnt[k] <= '0;
         end
      end else if (CLEAR) begin
         beat_cnt    <= '0;
         pkt_cnt     <= '0;
         last_result <= '0;
         done        <= 1'b0;
         dest_err    <= 1'b0;
         for (int k = 0; k < NID; k++) begin
            id_cnt[k] <= '0;
         end
      end else if (fifo_pop) begin
         beat_cnt <= CNTW'(sat_inc(32'(beat_cnt), 32'(CNT_MAX)));
         if (!dest_ok) begin
            dest_err <= 1'b1;
         end else if (head_last) begin
            pkt_cnt          <= pkt_next;
            id_cnt[head_tid] <= CNTW'(sat_inc(32'(id_cnt[head_tid]), 32'(CNT_MAX)));
            last_result      <= head_data[RESW-1:0];
            // DONE rises together with the count that reaches the target.
            if (32'(pkt_next) >= 32'(NUM_EXPECTED)) begin
               done <= 1'b1;
            end
         end
      end
   end

   // Master port: FIFO head in FORWARD mode, constant zero in SINK mode.
   always_comb begin
      AXIS_M_TVALID = 1'b0;
      AXIS_M_TDATA  = '0;
      AXIS_M_TLAST  = 1'b0;
      AXIS_M_TID    = '0;
      AXIS_M_TDEST  = '0;
      if (IS_FWD && !fifo_empty) begin
         AXIS_M_TVALID = 1'b1;
         AXIS_M_TDATA  = head_data;
         AXIS_M_TLAST  = head_last;
         AXIS_M_TID    = head_tid;
         AXIS_M_TDEST  = head_dest;
      end else begin
         AXIS_M_TVALID = 1'b0;
      end
   end

   // Flatten per-ID counters onto the output bus.
   always_comb begin
      ID_PKT_CNT = '0;
      for (int k = 0; k < NID; k++) begin
         ID_PKT_CNT[k*CNTW +: CNTW] = id_cnt[k];
      end
   end

   assign BEAT_CNT    = beat_cnt;
   assign PKT_CNT     = pkt_cnt;
   assign LAST_RESULT = last_result;
   assign DONE        = done;
   assign DEST_ERR    = dest_err;

endmodule

// File: tb/tb_noc_output_collector.sv
// -----------------------------------------------------------------------------
// tb_noc_output_collector
// Two collectors side by side: index 0 in FORWARD mode (CNTW=16), index 1 in
// SINK mode (CNTW=4). Both expect 4 packets for DONE. A queue-based reference
// model is compared against every output on every falling clock edge, and
// directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_noc_output_collector;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        clear    [2];
   logic        s_tvalid [2];
   logic        s_tlast  [2];
   logic [31:0] s_tdata  [2];
   logic [1:0]  s_tid    [2];
   logic [3:0]  s_tdest  [2];
   logic        m_tready [2];

   logic        done     [2];
   logic        derr     [2];
   logic        s_tready [2];
   logic        m_tvalid [2];
   logic        m_tlast  [2];
   logic [31:0] m_tdata  [2];
   logic [1:0]  m_tid    [2];
   logic [3:0]  m_tdest  [2];
   logic [8:0]  res      [2];
   logic [15:0] f_beat, f_pkt;
   logic [63:0] f_id;
   logic [3:0]  s_beat, s_pkt;
   logic [15:0] s_id;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   noc_output_collector #(.CNTW(16), .NUM_EXPECTED(4), .FORWARD(1)) u_fwd (
      .CLK(clk), .RST(rst), .CLEAR(clear[0]), .DONE(done[0]), .DEST_ERR(derr[0]),
      .BEAT_CNT(f_beat), .PKT_CNT(f_pkt), .ID_PKT_CNT(f_id), .LAST_RESULT(res[0]),
      .AXIS_S_TVALID(s_tvalid[0]), .AXIS_S_TREADY(s_tready[0]), .AXIS_S_TDATA(s_tdata[0]),
      .AXIS_S_TLAST(s_tlast[0]), .AXIS_S_TID(s_tid[0]), .AXIS_S_TDEST(s_tdest[0]),
      .AXIS_M_TVALID(m_tvalid[0]), .AXIS_M_TREADY(m_tready[0]), .AXIS_M_TDATA(m_tdata[0]),
      .AXIS_M_TLAST(m_tlast[0]), .AXIS_M_TID(m_tid[0]), .AXIS_M_TDEST(m_tdest[0]));

   noc_output_collector #(.CNTW(4), .NUM_EXPECTED(4), .FORWARD(0)) u_snk (
      .CLK(clk), .RST(rst), .CLEAR(clear[1]), .DONE(done[1]), .DEST_ERR(derr[1]),
      .BEAT_CNT(s_beat), .PKT_CNT(s_pkt), .ID_PKT_CNT(s_id), .LAST_RESULT(res[1]),
      .AXIS_S_TVALID(s_tvalid[1]), .AXIS_S_TREADY(s_tready[1]), .AXIS_S_TDATA(s_tdata[1]),
      .AXIS_S_TLAST(s_tlast[1]), .AXIS_S_TID(s_tid[1]), .AXIS_S_TDEST(s_tdest[1]),
      .AXIS_M_TVALID(m_tvalid[1]), .AXIS_M_TREADY(m_tready[1]), .AXIS_M_TDATA(m_tdata[1]),
      .AXIS_M_TLAST(m_tlast[1]), .AXIS_M_TID(m_tid[1]), .AXIS_M_TDEST(m_tdest[1]));

   // ---------------- reference model ----------------
   // Entry layout: {data[38:7], last[6], tid[5:4], dest[3:0]}
   int          FWDP [2] = '{1, 0};
   int          CMAX [2] = '{65535, 15};
   int          NEXP [2] = '{4, 4};
   logic [38:0] mq [2][$];
   int          m_beat [2];
   int          m_pkt [2];
   int          m_id [2][4];
   int          m_res [2];
   bit          m_done [2];
   bit          m_derr [2];
   bit          m_started [2];

   function automatic int sat(input int v, input int mx);
      return (v < mx) ? v + 1 : v;
   endfunction

   task automatic model_zero(input int i);
      m_beat[i] = 0; m_pkt[i] = 0; m_res[i] = 0; m_done[i] = 1'b0; m_derr[i] = 1'b0;
      for (int k = 0; k < 4; k++) m_id[i][k] = 0;
   endtask

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            mq[i].delete();
            model_zero(i);
            m_started[i] = 1'b0;
         end else begin
            logic [38:0] e;
            bit rdy, psh, pp;
            rdy = m_started[i] && (mq[i].size() < 8) && !clear[i];
            psh = s_tvalid[i] && rdy;
            pp  = !clear[i] && (mq[i].size() > 0) && ((FWDP[i] == 0) || m_tready[i]);
            if (clear[i]) begin
               mq[i].delete();
               model_zero(i);
            end else begin
               if (pp) begin
                  e = mq[i].pop_front();
                  m_beat[i] = sat(m_beat[i], CMAX[i]);
                  if (e[3:0] != 4'd0) begin
                     m_derr[i] = 1'b1;
                  end else if (e[6]) begin
                     m_pkt[i] = sat(m_pkt[i], CMAX[i]);
                     m_id[i][e[5:4]] = sat(m_id[i][e[5:4]], CMAX[i]);
                     m_res[i] = int'(e[15:7]);
                     if (m_pkt[i] >= NEXP[i]) m_done[i] = 1'b1;
                  end
               end
               if (psh) mq[i].push_back({s_tdata[i], s_tlast[i], s_tid[i], s_tdest[i]});
            end
            m_started[i] = 1'b1;
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input int i, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s[%0d] actual=0x%0h expected=0x%0h at %0t", name, i, act, exp, $time);
      end
   endtask

   function automatic longint act_beat(input int i);
      return (i == 0) ? longint'(f_beat) : longint'(s_beat);
   endfunction
   function automatic longint act_pkt(input int i);
      return (i == 0) ? longint'(f_pkt) : longint'(s_pkt);
   endfunction
   function automatic longint act_id(input int i, input int k);
      return (i == 0) ? longint'(f_id[k*16 +: 16]) : longint'(s_id[k*4 +: 4]);
   endfunction

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic [38:0] h;
         bit erdy, evld;
         erdy = m_started[i] && (mq[i].size() < 8) && !clear[i];
         evld = (FWDP[i] == 1) && (mq[i].size() > 0);
         chk("s_tready", i, s_tready[i], erdy);
         chk("done", i, done[i], m_done[i]);
         chk("dest_err", i, derr[i], m_derr[i]);
         chk("beat_cnt", i, act_beat(i), m_beat[i]);
         chk("pkt_cnt", i, act_pkt(i), m_pkt[i]);
         chk("last_result", i, res[i], m_res[i]);
         for (int k = 0; k < 4; k++) chk("id_pkt_cnt", i, act_id(i, k), m_id[i][k]);
         chk("m_tvalid", i, m_tvalid[i], evld);
         if (evld) begin
            h = mq[i][0];
            chk("m_tdata", i, m_tdata[i], h[38:7]);
            chk("m_tlast", i, m_tlast[i], h[6]);
            chk("m_tid", i, m_tid[i], h[5:4]);
            chk("m_tdest", i, m_tdest[i], h[3:0]);
         end else if (FWDP[i] == 0) begin
            chk("sink_m_zero", i, {m_tdata[i], m_tlast[i], m_tid[i], m_tdest[i]}, 0);
         end
      end
   end

   // Forward-port output log for order/duplicate checks.
   logic [31:0] fq [$];
   always @(negedge clk) begin
      if (!rst && m_tvalid[0] && m_tready[0]) fq.push_back(m_tdata[0]);
   end

   // ---------------- stimulus ----------------
   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) sync();
   endtask

   task automatic send(input int i, input logic [31:0] d, input logic l, input logic [1:0] t,
                       input logic [3:0] de, input int budget, output bit ok);
      s_tvalid[i] = 1'b1; s_tdata[i] = d; s_tlast[i] = l; s_tid[i] = t; s_tdest[i] = de;
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge clk);
         if (s_tready[i]) ok = 1'b1;
         sync();
      end
      s_tvalid[i] = 1'b0;
   endtask

   task automatic send_ok(input int i, input logic [31:0] d, input logic l, input logic [1:0] t,
                          input logic [3:0] de);
      bit ok;
      send(i, d, l, t, de, 20, ok);
      chk("accept_timeout", i, ok, 1);
   endtask

   task automatic chk_stream(input string name, input logic [31:0] exp_q [$]);
      chk({name, "_len"}, 0, fq.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
         chk(name, k, (k < fq.size()) ? fq[k] : 32'hDEAD_BEEF, exp_q[k]);
   endtask

   initial begin
      logic [31:0] exp_q [$];
      bit ok;
      for (int i = 0; i < 2; i++) begin
         clear[i] = 1'b0; s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0; s_tdata[i] = 32'd0;
         s_tid[i] = 2'd0; s_tdest[i] = 4'd0; m_tready[i] = 1'b0;
      end
      idle(2);
      @(negedge clk);
      chk("reset_tready", 0, s_tready[0], 0);
      chk("reset_beat", 1, act_beat(1), 0);
      sync();
      rst = 1'b0;
      idle(2);

      // FORWARD: three 2-beat packets, TID 1, M_TREADY high.
      m_tready[0] = 1'b1;
      fq.delete();
      for (int p = 0; p < 3; p++) begin
         send_ok(0, 32'h1000 + 32'(p), 1'b0, 2'd1, 4'd0);
         send_ok(0, 32'h0000_01A5, 1'b1, 2'd1, 4'd0);
      end
      idle(5);
      @(negedge clk);
      chk("t1_pkt", 0, act_pkt(0), 3);
      chk("t1_beat", 0, act_beat(0), 6);
      chk("t1_id1", 0, act_id(0, 1), 3);
      chk("t1_result", 0, res[0], 9'h1A5);
      chk("t1_done", 0, done[0], 0);
      exp_q = '{32'h1000, 32'h1A5, 32'h1001, 32'h1A5, 32'h1002, 32'h1A5};
      chk_stream("t1_stream", exp_q);
      sync();

      // FORWARD backpressure: 10 beats against a stalled master.
      m_tready[0] = 1'b0;
      fq.delete();
      for (int k = 0; k < 8; k++) send_ok(0, 32'hA0 + 32'(k), 1'b1, 2'(k), 4'd0);
      send(0, 32'hA8, 1'b1, 2'd0, 4'd0, 6, ok);
      chk("t2_ninth_blocked", 0, ok, 0);
      m_tready[0] = 1'b1;
      send_ok(0, 32'hA8, 1'b1, 2'd0, 4'd0);
      send_ok(0, 32'hA9, 1'b1, 2'd1, 4'd0);
      idle(12);
      @(negedge clk);
      exp_q.delete();
      for (int k = 0; k < 10; k++) exp_q.push_back(32'hA0 + 32'(k));
      chk_stream("t2_stream", exp_q);
      chk("t2_pkt", 0, act_pkt(0), 13);
      chk("t2_beat", 0, act_beat(0), 16);
      chk("t2_id1", 0, act_id(0, 1), 6);
      chk("t2_result", 0, res[0], 9'h0A9);
      chk("t2_done", 0, done[0], 1);
      sync();

      // CLEAR with 5 beats buffered and DONE set.
      m_tready[0] = 1'b0;
      for (int k = 0; k < 5; k++) send_ok(0, 32'hB0 + 32'(k), 1'b1, 2'd0, 4'd0);
      clear[0] = 1'b1;
      s_tvalid[0] = 1'b1; s_tdata[0] = 32'hBF; s_tlast[0] = 1'b1;
      @(negedge clk);
      chk("t3_tready_in_clear", 0, s_tready[0], 0);
      chk("t3_done_before", 0, done[0], 1);
      sync();
      clear[0] = 1'b0; s_tvalid[0] = 1'b0;
      @(negedge clk);
      chk("t3_mvalid", 0, m_tvalid[0], 0);
      chk("t3_pkt", 0, act_pkt(0), 0);
      chk("t3_beat", 0, act_beat(0), 0);
      chk("t3_done", 0, done[0], 0);
      sync();

      // SINK: DONE after the 4th single-beat packet.
      for (int k = 0; k < 4; k++) send_ok(1, 32'h100 + 32'(k), 1'b1, 2'(k), 4'd0);
      @(negedge clk);
      chk("t4_pkt_pre", 1, act_pkt(1), 3);
      chk("t4_done_pre", 1, done[1], 0);
      sync();
      @(negedge clk);
      chk("t4_pkt", 1, act_pkt(1), 4);
      chk("t4_done", 1, done[1], 1);
      sync();
      send_ok(1, 32'h104, 1'b1, 2'd0, 4'd0);
      idle(3);
      @(negedge clk);
      chk("t4_pkt5", 1, act_pkt(1), 5);
      chk("t4_done_sticky", 1, done[1], 1);
      chk("t4_result", 1, res[1], 9'h104);
      sync();

      // SINK: wrong destination.
      send_ok(1, 32'h0FF, 1'b1, 2'd2, 4'd3);
      idle(3);
      @(negedge clk);
      chk("t5_derr", 1, derr[1], 1);
      chk("t5_beat", 1, act_beat(1), 6);
      chk("t5_pkt", 1, act_pkt(1), 5);
      chk("t5_result", 1, res[1], 9'h104);
      sync();

      // SINK with 4-bit counters: 20 more packets saturate.
      for (int k = 0; k < 20; k++) send_ok(1, 32'h200 + 32'(k), 1'b1, 2'(k), 4'd0);
      idle(3);
      @(negedge clk);
      chk("t6_pkt_sat", 1, act_pkt(1), 15);
      chk("t6_beat_sat", 1, act_beat(1), 15);
      chk("t6_id3", 1, act_id(1, 3), 6);
      chk("t6_result", 1, res[1], 9'h013);
      sync();

      // Asynchronous reset mid-stream.
      m_tready[0] = 1'b0;
      for (int k = 0; k < 3; k++) send_ok(0, 32'hC0 + 32'(k), 1'b0, 2'd0, 4'd0);
      s_tvalid[0] = 1'b1; s_tdata[0] = 32'hC3;
      #2 rst = 1'b1;
      #1;
      chk("t7_mvalid", 0, m_tvalid[0], 0);
      chk("t7_tready", 0, s_tready[0], 0);
      chk("t7_pkt", 1, act_pkt(1), 0);
      chk("t7_beat", 1, act_beat(1), 0);
      chk("t7_done", 1, done[1], 0);
      chk("t7_derr", 1, derr[1], 0);
      chk("t7_result", 1, res[1], 0);
      s_tvalid[0] = 1'b0;
      idle(2);
      rst = 1'b0;
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/noc_output_collector.md
Name: noc_output_collector

Overview:
Parametrised NoC egress endpoint that terminates an AXI-Stream link. It buffers incoming beats in a DEPTH-entry FIFO and counts beats and packets, both in total and per TID. It checks TDEST against the local address, captures the last packet result, and raises DONE after NUM_EXPECTED good packets. In SINK mode the FIFO drains internally; in FORWARD mode beats pass unchanged to the master port with full backpressure.

Parameters:
TDATAW, 32, data width
TDESTW, 4, destination width
TIDW, 2, ID width; 2**TIDW per-ID packet counters
DEPTH, 8, FIFO entries, power of 2, >=2
CNTW, 16, width of every counter
RESW, 9, result field = TDATA[RESW-1:0] (RESW<=TDATAW)
LOCAL_DEST, 0, expected TDEST value
NUM_EXPECTED, 16, good packets required for DONE (1..2**CNTW-1)
FORWARD, 0, 0=SINK, 1=FORWARD

Ports:
CLK  in  1  clock
RST  in  1  async active-high reset
CLEAR  in  1  sync flush/restart
DONE  out  1  sticky; good packet count reached NUM_EXPECTED
DEST_ERR  out  1  sticky; a beat with TDEST!=LOCAL_DEST was popped
BEAT_CNT  out  CNTW  popped beats
PKT_CNT  out  CNTW  popped good packets (TLAST beats, matching dest)
ID_PKT_CNT  out  (2**TIDW)*CNTW  good packets per TID, TID k at [k*CNTW +: CNTW]
LAST_RESULT  out  RESW  TDATA[RESW-1:0] of last good TLAST beat
AXIS_S_TVALID/TREADY/TDATA/TLAST/TID/TDEST  in/out/in/in/in/in  1/1/TDATAW/1/TIDW/TDESTW  slave stream
AXIS_M_TVALID/TREADY/TDATA/TLAST/TID/TDEST  out/in/out/out/out/out  1/1/TDATAW/1/TIDW/TDESTW  master stream

Behaviour:
- Reset (RST high, async): FIFO empty; all counters, LAST_RESULT, DONE and DEST_ERR are 0; AXIS_S_TREADY=0; AXIS_M_TVALID=0.
- FIFO entry = {TDATA,TLAST,TID,TDEST}. Push on S_TVALID&&S_TREADY.
- AXIS_S_TREADY = !full && !CLEAR, driven from registered state only and never from S_TVALID. No push while full.
- Pop condition:
  - SINK: !empty, at one entry per cycle.
  - FORWARD: M_TVALID&&M_TREADY.
- Latency: a beat pushed in cycle N is poppable in N+1. There is no same-cycle bypass when empty.
- Push and pop in the same cycle leave occupancy unchanged. Pointers wrap modulo DEPTH, with full/empty decided by an extra pointer bit.
- FORWARD: AXIS_M_* presents the FIFO head, with M_TVALID=!empty. Head and valid hold stable until accepted (AXI rule).
- SINK: all AXIS_M_* outputs are 0.
- On pop:
  - BEAT_CNT++.
  - If head TDEST!=LOCAL_DEST: set DEST_ERR; no packet or ID counts.
  - Else if TLAST: PKT_CNT++, ID_PKT_CNT[TID]++, and LAST_RESULT<=TDATA[RESW-1:0].
- All counters saturate at 2**CNTW-1 and never wrap.
- DONE is registered. It goes high the cycle after the pop that brings PKT_CNT to NUM_EXPECTED and stays high until RST or CLEAR. Beats after DONE are still accepted and counted.
- CLEAR (synchronous, priority over push/pop): FIFO flushed; counters, LAST_RESULT, DONE and DEST_ERR cleared next edge. Any beat presented during CLEAR is not accepted (TREADY=0).
- RST mid-packet discards buffered beats. No partial-packet recovery.
- FORWARD mode keeps the counters, so the block works as an in-line monitor.

Decomposition:
- Package noc_out_pkg: mode constants MODE_SINK=0, MODE_FORWARD=1; function clog2-based pointer width helper; saturating-increment function.
- Sub-module noc_sync_fifo: parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, clear; same CLK/RST.
- The top level holds the counters, checks and mode muxing.

Test Plan:
- FORWARD, M_TREADY=1, three 2-beat packets TID=1 TDEST=0, last TDATA=0x0000_01A5 -> PKT_CNT=3, BEAT_CNT=6, ID_PKT_CNT[1]=3, LAST_RESULT=0x1A5, M stream identical and in order.
- FORWARD, M_TREADY=0, 10 beats offered with DEPTH=8 -> exactly 8 accepted, S_TREADY=0 while full. Release TREADY -> all 10 emerge in order with no duplicates.
- SINK, NUM_EXPECTED=4, four 1-beat packets -> DONE=1 one cycle after the 4th pop. A 5th packet keeps DONE=1, PKT_CNT=5, and M_TVALID stays 0 throughout.
- One packet with TDEST=3, LOCAL_DEST=0 -> DEST_ERR=1, BEAT_CNT=1, PKT_CNT=0, LAST_RESULT unchanged.
- CNTW=4, 20 good packets -> PKT_CNT saturates at 15.
- CLEAR pulsed with 5 beats buffered and DONE=1 -> next cycle: empty, counters=0, DONE=0, TREADY=0 during CLEAR. RST asserted mid-stream -> all outputs are at reset values asynchronously.
